// File: rtl/jedro_1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_pkg
// Brief    : Shared types and default widths for the jedro_1 writeback path.
// Revision : 1.0 - initial release
// ============================================================================
package jedro_1_pkg;

    localparam int DATA_WIDTH_DEF     = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage : jedro_1_pkg
`default_nettype wire

// File: rtl/jedro_1_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_wb_scoreboard
// Brief    : Pending-load bit per register and read-after-write hazard detect.
// Revision : 1.0 - initial release
// ============================================================================
module jedro_1_wb_scoreboard
    import jedro_1_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      set_i,
    input  logic [REG_ADDR_WIDTH-1:0] set_addr_i,
    input  logic                      clr_i,
    input  logic [REG_ADDR_WIDTH-1:0] clr_addr_i,
    input  logic                      wpc_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] wpc_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rpa_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rpb_addr_i,
    output logic                      hazard_o
);

    localparam int NUM_REGISTERS = 2 ** REG_ADDR_WIDTH;

    logic [NUM_REGISTERS-1:0] pending_q;
    logic [NUM_REGISTERS-1:0] pending_d;
    logic                     hazard_a;
    logic                     hazard_b;

    // Set is applied after clear so a load re-issued on its own commit cycle stays pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (set_i) begin
            pending_d[set_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // The in-flight write is also a hazard: the regfile only updates at the end of that cycle.
    always_comb begin
        hazard_a = (rpa_addr_i != '0) &&
                   (pending_q[rpa_addr_i] || (wpc_we_i && (wpc_addr_i == rpa_addr_i)));
        hazard_b = (rpb_addr_i != '0) &&
                   (pending_q[rpb_addr_i] || (wpc_we_i && (wpc_addr_i == rpb_addr_i)));
        hazard_o = hazard_a || hazard_b;
    end

endmodule : jedro_1_wb_scoreboard
`default_nettype wire

// File: rtl/jedro_1_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_wb_arbiter
// Brief    : Arbitrates ALU/LSU writeback onto regfile port C, registered output.
//            Macro JEDRO_1_WB_RR_EN selects round-robin on conflict; default is
//            fixed LSU priority.
// Revision : 1.0 - initial release
// ============================================================================
module jedro_1_wb_arbiter
    import jedro_1_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      alu_valid_i,
    output logic                      alu_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] alu_addr_i,
    input  logic [DATA_WIDTH-1:0]     alu_data_i,
    input  logic                      lsu_valid_i,
    output logic                      lsu_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]     lsu_data_i,
    input  logic                      load_issue_i,
    input  logic [REG_ADDR_WIDTH-1:0] load_issue_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rpa_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rpb_addr_i,
    output logic                      hazard_o,
    output logic                      wpc_we_o,
    output logic [REG_ADDR_WIDTH-1:0] wpc_addr_o,
    output logic [DATA_WIDTH-1:0]     wpc_data_o
);

    logic                      alu_gnt;
    logic                      lsu_gnt;
    logic                      conflict;
    logic                      wpc_we_q;
    logic [REG_ADDR_WIDTH-1:0] wpc_addr_q;
    logic [DATA_WIDTH-1:0]     wpc_data_q;
    wb_src_e                   src_q;

    assign conflict = alu_valid_i && lsu_valid_i;

`ifdef JEDRO_1_WB_RR_EN
    wb_src_e rr_ptr_q;

    // Pointer hands preference to whoever lost the last conflict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= WB_SRC_LSU;
        end else if (conflict) begin
            rr_ptr_q <= (rr_ptr_q == WB_SRC_LSU) ? WB_SRC_ALU : WB_SRC_LSU;
        end
    end
`endif

    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (!rst_i) begin
            if (conflict) begin
`ifdef JEDRO_1_WB_RR_EN
                lsu_gnt = (rr_ptr_q == WB_SRC_LSU);
                alu_gnt = (rr_ptr_q == WB_SRC_ALU);
`else
                lsu_gnt = 1'b1;
`endif
            end else begin
                alu_gnt = alu_valid_i;
                lsu_gnt = lsu_valid_i;
            end
        end
    end

    assign alu_ready_o = alu_gnt;
    assign lsu_ready_o = lsu_gnt;

    // x0 grants are accepted but leave address/data holding their last values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wpc_we_q   <= 1'b0;
            wpc_addr_q <= '0;
            wpc_data_q <= '0;
            src_q      <= WB_SRC_ALU;
        end else begin
            wpc_we_q <= 1'b0;
            if (lsu_gnt && (lsu_addr_i != '0)) begin
                wpc_we_q   <= 1'b1;
                wpc_addr_q <= lsu_addr_i;
                wpc_data_q <= lsu_data_i;
                src_q      <= WB_SRC_LSU;
            end else if (alu_gnt && (alu_addr_i != '0)) begin
                wpc_we_q   <= 1'b1;
                wpc_addr_q <= alu_addr_i;
                wpc_data_q <= alu_data_i;
                src_q      <= WB_SRC_ALU;
            end
        end
    end

    assign wpc_we_o   = wpc_we_q;
    assign wpc_addr_o = wpc_addr_q;
    assign wpc_data_o = wpc_data_q;

    jedro_1_wb_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (load_issue_i),
        .set_addr_i (load_issue_addr_i),
        .clr_i      (wpc_we_q && (src_q == WB_SRC_LSU)),
        .clr_addr_i (wpc_addr_q),
        .wpc_we_i   (wpc_we_q),
        .wpc_addr_i (wpc_addr_q),
        .rpa_addr_i (rpa_addr_i),
        .rpb_addr_i (rpb_addr_i),
        .hazard_o   (hazard_o)
    );

endmodule : jedro_1_wb_arbiter
`default_nettype wire

// File: tb/tb_jedro_1_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jedro_1_wb_arbiter
// Brief    : Directed self-checking bench for jedro_1_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jedro_1_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_addr_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        load_issue_i;
    logic [4:0]  load_issue_addr_i;
    logic [4:0]  rpa_addr_i;
    logic [4:0]  rpb_addr_i;
    logic        hazard_o;
    logic        wpc_we_o;
    logic [4:0]  wpc_addr_o;
    logic [31:0] wpc_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    jedro_1_wb_arbiter dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .alu_valid_i       (alu_valid_i),
        .alu_ready_o       (alu_ready_o),
        .alu_addr_i        (alu_addr_i),
        .alu_data_i        (alu_data_i),
        .lsu_valid_i       (lsu_valid_i),
        .lsu_ready_o       (lsu_ready_o),
        .lsu_addr_i        (lsu_addr_i),
        .lsu_data_i        (lsu_data_i),
        .load_issue_i      (load_issue_i),
        .load_issue_addr_i (load_issue_addr_i),
        .rpa_addr_i        (rpa_addr_i),
        .rpb_addr_i        (rpb_addr_i),
        .hazard_o          (hazard_o),
        .wpc_we_o          (wpc_we_o),
        .wpc_addr_o        (wpc_addr_o),
        .wpc_data_o        (wpc_data_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        alu_valid_i = 1'b1; alu_addr_i = 5'd5; alu_data_i = 32'h1111_1111;
        lsu_valid_i = 1'b1; lsu_addr_i = 5'd6; lsu_data_i = 32'h2222_2222;
        load_issue_i = 1'b0; load_issue_addr_i = 5'd0;
        rpa_addr_i = 5'd5; rpb_addr_i = 5'd7;

        // Reset held for two cycles
        tick();
        check_eq("rst_alu_ready", alu_ready_o, 0);
        check_eq("rst_lsu_ready", lsu_ready_o, 0);
        tick();
        check_eq("rst_we", wpc_we_o, 0);
        check_eq("rst_addr", wpc_addr_o, 0);
        check_eq("rst_data", wpc_data_o, 0);
        check_eq("rst_hazard", hazard_o, 0);
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        rst_i = 1'b0;
        tick();

        // Single ALU write to x5
        alu_valid_i = 1'b1; alu_addr_i = 5'd5; alu_data_i = 32'hDEAD_BEEF;
        rpa_addr_i = 5'd5; rpb_addr_i = 5'd0;
        settle();
        check_eq("alu_ready_N", alu_ready_o, 1);
        check_eq("lsu_ready_N", lsu_ready_o, 0);
        check_eq("hazard_N", hazard_o, 0);
        tick();
        alu_valid_i = 1'b0;
        check_eq("alu_we_N1", wpc_we_o, 1);
        check_eq("alu_addr_N1", wpc_addr_o, 5);
        check_eq("alu_data_N1", wpc_data_o, 32'hDEAD_BEEF);
        check_eq("alu_hazard_N1", hazard_o, 1);
        tick();
        check_eq("alu_we_N2", wpc_we_o, 0);
        check_eq("alu_hazard_N2", hazard_o, 0);
        check_eq("alu_data_hold", wpc_data_o, 32'hDEAD_BEEF);

        // Conflict: ALU x3 vs LSU x4
        rpa_addr_i = 5'd0;
        alu_valid_i = 1'b1; alu_addr_i = 5'd3; alu_data_i = 32'h0000_0033;
        lsu_valid_i = 1'b1; lsu_addr_i = 5'd4; lsu_data_i = 32'h0000_0044;
        settle();
        check_eq("cf1_lsu_ready", lsu_ready_o, 1);
        check_eq("cf1_alu_ready", alu_ready_o, 0);
`ifdef JEDRO_1_WB_RR_EN
        tick();
        lsu_data_i = 32'h0000_0045;
        check_eq("rr1_addr", wpc_addr_o, 4);
        check_eq("rr1_data", wpc_data_o, 32'h44);
        settle();
        check_eq("rr2_alu_ready", alu_ready_o, 1);
        check_eq("rr2_lsu_ready", lsu_ready_o, 0);
        tick();
        alu_data_i = 32'h0000_0034;
        check_eq("rr2_we", wpc_we_o, 1);
        check_eq("rr2_addr", wpc_addr_o, 3);
        check_eq("rr2_data", wpc_data_o, 32'h33);
        settle();
        check_eq("rr3_lsu_ready", lsu_ready_o, 1);
        check_eq("rr3_alu_ready", alu_ready_o, 0);
        tick();
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        check_eq("rr3_we", wpc_we_o, 1);
        check_eq("rr3_addr", wpc_addr_o, 4);
        check_eq("rr3_data", wpc_data_o, 32'h45);
`else
        tick();
        lsu_valid_i = 1'b0;
        check_eq("fp1_we", wpc_we_o, 1);
        check_eq("fp1_addr", wpc_addr_o, 4);
        check_eq("fp1_data", wpc_data_o, 32'h44);
        settle();
        check_eq("fp2_alu_ready", alu_ready_o, 1);
        tick();
        alu_valid_i = 1'b0;
        check_eq("fp2_we", wpc_we_o, 1);
        check_eq("fp2_addr", wpc_addr_o, 3);
        check_eq("fp2_data", wpc_data_o, 32'h33);
`endif
        tick();

        // Load hazard on x7 via read port B
        rpa_addr_i = 5'd0; rpb_addr_i = 5'd7;
        load_issue_i = 1'b1; load_issue_addr_i = 5'd7;
        settle();
        check_eq("ld_issue_hazard", hazard_o, 0);
        tick();
        load_issue_i = 1'b0;
        check_eq("ld_pending_hazard", hazard_o, 1);
        alu_valid_i = 1'b1; alu_addr_i = 5'd7; alu_data_i = 32'h0000_0077;
        tick();
        alu_valid_i = 1'b0;
        check_eq("ld_alu_we", wpc_we_o, 1);
        check_eq("ld_alu_hazard", hazard_o, 1);
        tick();
        check_eq("ld_after_alu_hazard", hazard_o, 1);
        lsu_valid_i = 1'b1; lsu_addr_i = 5'd7; lsu_data_i = 32'h0000_0070;
        tick();
        lsu_valid_i = 1'b0;
        check_eq("ld_commit1_we", wpc_we_o, 1);
        check_eq("ld_commit1_data", wpc_data_o, 32'h70);
        load_issue_i = 1'b1; load_issue_addr_i = 5'd7;
        tick();
        load_issue_i = 1'b0;
        check_eq("ld_reissue_hazard", hazard_o, 1);
        lsu_valid_i = 1'b1; lsu_addr_i = 5'd7; lsu_data_i = 32'h0000_0071;
        tick();
        lsu_valid_i = 1'b0;
        check_eq("ld_commit2_hazard", hazard_o, 1);
        tick();
        check_eq("ld_cleared_hazard", hazard_o, 0);

        // x0 write is accepted but never written
        alu_valid_i = 1'b1; alu_addr_i = 5'd0; alu_data_i = 32'hFFFF_FFFF;
        settle();
        check_eq("x0_ready", alu_ready_o, 1);
        tick();
        alu_valid_i = 1'b0;
        check_eq("x0_we", wpc_we_o, 0);
        check_eq("x0_addr_hold", wpc_addr_o, 7);
        check_eq("x0_data_hold", wpc_data_o, 32'h71);

        // Reset mid-operation: pending load and in-flight write are dropped
        rpa_addr_i = 5'd9; rpb_addr_i = 5'd10;
        load_issue_i = 1'b1; load_issue_addr_i = 5'd9;
        tick();
        load_issue_i = 1'b0;
        check_eq("mid_pending_hazard", hazard_o, 1);
        alu_valid_i = 1'b1; alu_addr_i = 5'd10; alu_data_i = 32'h0000_00AA;
        tick();
        alu_valid_i = 1'b0;
        check_eq("mid_inflight_we", wpc_we_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_eq("mid_rst_we", wpc_we_o, 0);
        check_eq("mid_rst_addr", wpc_addr_o, 0);
        check_eq("mid_rst_hazard", hazard_o, 0);
        tick();
        check_eq("post_rst_hazard", hazard_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_jedro_1_wb_arbiter
`default_nettype wire

// File: doc/jedro_1_wb_arbiter.md
# jedro_1_wb_arbiter

- Shares the single register-file write port (port C) between the ALU and load/store unit (LSU) writeback paths.
- Drives the port from a registered output stage.
- Keeps a per-register pending-load scoreboard and flags read-after-write hazards on the two register-file read addresses so decode can stall.
- Sits between execute/LSU writeback and `jedro_1_regfile`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width.
- `REG_ADDR_WIDTH`, 5, register address width; `NUM_REGISTERS = 2**REG_ADDR_WIDTH`.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `alu_valid_i` in 1: ALU writeback request.
- `alu_ready_o` out 1: ALU request granted this cycle (combinational).
- `alu_addr_i` in `REG_ADDR_WIDTH`: ALU destination register.
- `alu_data_i` in `DATA_WIDTH`: ALU result.
- `lsu_valid_i` in 1: LSU load-data writeback request.
- `lsu_ready_o` out 1: LSU request granted this cycle (combinational).
- `lsu_addr_i` in `REG_ADDR_WIDTH`: load destination register.
- `lsu_data_i` in `DATA_WIDTH`: load data.
- `load_issue_i` in 1: a load was issued; mark its destination pending.
- `load_issue_addr_i` in `REG_ADDR_WIDTH`: destination of the issued load.
- `rpa_addr_i` in `REG_ADDR_WIDTH`: decode read address A (same as regfile port A).
- `rpb_addr_i` in `REG_ADDR_WIDTH`: decode read address B.
- `hazard_o` out 1: read A or B targets a register not yet readable (combinational).
- `wpc_we_o` out 1: regfile write enable (registered).
- `wpc_addr_o` out `REG_ADDR_WIDTH`: regfile write address (registered).
- `wpc_data_o` out `DATA_WIDTH`: regfile write data (registered).

## Operation
**Handshake**
- Valid/ready per requester.
- A transfer occurs when valid && ready.
- Once valid is raised, the requester holds valid, addr and data stable until ready.
- `ready` never depends on `ready` of the other requester's inputs beyond its valid.

**Arbitration**
- Exactly one requester is granted per cycle.
- Single valid: that requester is granted.
- Both valid: the winner is chosen by the priority rule (see Configuration); the loser sees ready=0 and retries next cycle.

**Output stage**
- On a grant with addr != 0, the next cycle drives `wpc_we_o`=1 with the granted addr/data.
- Otherwise `wpc_we_o`=0; `wpc_addr_o`/`wpc_data_o` hold their last values.

**x0 writes**
- A write to x0 is accepted (ready=1) but never produces `wpc_we_o`.

**Scoreboard**
- Holds one pending bit per register; bit 0 is hardwired 0.
- `load_issue_i` with addr != 0 sets `pending[addr]`.
- A register's pending bit clears on the edge that ends the cycle where `wpc_we_o`=1 for an LSU-sourced write to that register.
- The output stage therefore carries a 1-bit source tag.
- Simultaneous set and clear of the same register: set wins, because the newer load is outstanding.

**Hazard**
- `hazard_o` = (addr != 0) && (`pending[addr]` || (`wpc_we_o` && `wpc_addr_o`==addr)), evaluated for A, then ORed with the same term for B.

## Timing
**Reset values**
- Reset state while `rst_i`=1, sampled on the edge: `wpc_we_o`=0, `wpc_addr_o`=0, `wpc_data_o`=0, all pending bits 0, source tag 0, round-robin pointer = LSU-first.
- `alu_ready_o`/`lsu_ready_o` are forced 0 while `rst_i`=1.

**Reset mid-operation**
- Pending loads are forgotten.
- An in-flight output-stage write is dropped: `wpc_we_o` is 0 in the cycle after reset is sampled.

**Write latency**
- Grant in cycle N → `wpc_we_o` in cycle N+1 → regfile updated at the end of N+1 → new value readable from N+2.
- `hazard_o` covers the N+1 window for both ALU and LSU writes.

**Throughput**
- One write per cycle sustained, with no bubbles between back-to-back grants.

**Hazard path**
- `hazard_o` is purely combinational from the read addresses and registered state; there is no path from the valid inputs.

## Configuration
- Macro: `JEDRO_1_WB_RR_EN`.
- Defined: round-robin on conflict. A 1-bit pointer names the preferred requester. After a conflict cycle the pointer moves to the loser. Non-conflict grants leave it unchanged.
- Undefined: fixed priority, LSU always wins a conflict. The pointer register is not instantiated.
- Rationale for LSU-first: load latency is on the critical path, and ALU results are typically forwarded.

## Structure
- Shared package `jedro_1_pkg` holds:
  - enum `wb_src_e` {`WB_SRC_ALU`, `WB_SRC_LSU`}, used for the source tag and the RR pointer;
  - default `DATA_WIDTH`/`REG_ADDR_WIDTH` constants.
- Sub-module `jedro_1_wb_scoreboard` contains the pending-bit array, set/clear logic and hazard compare; it is instantiated once.
- Arbitration and the output stage stay in the top module.

## Test plan
- **Reset:** assert `rst_i` for 2 cycles → `wpc_we_o`=0, `hazard_o`=0 for any addresses, both ready=0 during reset.
- **Single ALU write:** ALU valid, addr 5, data 0xDEADBEEF in cycle N → `alu_ready_o`=1 in N; `wpc_we_o`=1, addr 5, data 0xDEADBEEF in N+1; `hazard_o`=1 for `rpa_addr_i`=5 in N+1 and 0 in N+2.
- **Conflict, macro undefined:** ALU (x3) and LSU (x4) valid for 2 cycles → LSU written first, ALU second, on consecutive cycles.
- **Conflict, macro defined:** with the pointer at LSU, three consecutive conflict cycles → grant order LSU, ALU, LSU.
- **Load hazard:** `load_issue_i` for x7 → `hazard_o`=1 for `rpb_addr_i`=7 until the cycle after the LSU write to x7 has `wpc_we_o`=1. An ALU write to x7 does not clear it. A load issue to x7 in the LSU commit cycle keeps it pending.
- **x0 and reset mid-operation:** ALU write to x0 → ready=1, `wpc_we_o` stays 0. `load_issue_i` for x9 followed by reset → pending cleared, `hazard_o`=0 for x9.
